clk_switch_ctrl: RTL
====================

// Module: clk_switch_ctrl
// PURPOSE
//   Sequencer for the glitch-free two-source clock switch. Accepts switch requests over a
//   valid/ready handshake, drives the switch's clk_sel, waits for the switch's cross-domain
//   gating chains to settle, holds off further switching for a minimum dwell time, then
//   signals completion. Runs on the always-on control clock. The CLK_SWITCH instance is
//   driven with clk_sel from this block, and its own resets stay with their source clocks.
// PARAMETERS
//   SETTLE_CYC  16  clk cycles after a clk_sel change before cur_sel updates; >=4
//   DWELL_CYC   64  clk cycles of minimum hold after settle before the next request; >=1
//   SWCNT_W     16  width of sw_cnt; used only with CLK_SW_CNT_EN
// PORTS
//   clk        in   1        control clock, free-running, independent of both switched sources
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   1        switch request valid
//   req_sel    in   1        requested source: 0 = clk_a, 1 = clk_b
//   req_ready  out  1        request accepted when req_valid & req_ready at posedge clk
//   clk_sel    out  1        registered select to the clock switch
//   cur_sel    out  1        source known to be driving clk_out, updated after settle
//   busy       out  1        state != IDLE
//   done       out  1        1-cycle pulse: request complete
//   sw_cnt     out  SWCNT_W  completed real switches; port exists only with CLK_SW_CNT_EN
// BEHAVIOUR
//   Reset values: clk_sel=0, cur_sel=0, busy=0, done=0, sw_cnt=0, state=IDLE.
//   clk_sel=0 at reset matches the switch's own reset, so the clk_a path is enabled.
//   Reset clears state asynchronously and releases synchronously to clk.
//   FSM: IDLE -> SETTLE -> DWELL -> DONE -> IDLE, plus IDLE -> DONE.
//   req_ready = (state==IDLE), decoded from the registered state only.
//   IDLE, accept with req_sel==cur_sel: no clk_sel change; go to DONE next cycle.
//   IDLE, accept with req_sel!=cur_sel:
//     - at the same edge, clk_sel<=req_sel, cnt<=SETTLE_CYC-1, state<=SETTLE
//   SETTLE: cnt decrements each cycle. At cnt==0: cur_sel<=clk_sel, cnt<=DWELL_CYC-1, go to DWELL.
//   DWELL: cnt decrements each cycle. At cnt==0, go to DONE.
//   DONE: done=1 for exactly one cycle, then go to IDLE. req_ready stays 0 during DONE.
//   Latency with acceptance at edge T:
//     - clk_sel changes in cycle T+1
//     - cur_sel changes at T+1+SETTLE_CYC
//     - done is high in cycle T+1+SETTLE_CYC+DWELL_CYC
//     - same-select request: done is high in cycle T+1
//   req_sel is sampled only at acceptance. req_valid while busy is ignored and is not queued.
//   req_valid high in the DONE cycle is accepted in the following IDLE cycle.
//   Reset mid-operation: all outputs return to reset values. Any partial switch is abandoned,
//   and the clock switch must be reset alongside.
//   Down-counter width CW = $clog2(max(SETTLE_CYC,DWELL_CYC)). The counter never wraps, and
//   it is don't-care in IDLE and DONE.
//   Elaboration $error if SETTLE_CYC<4 or DWELL_CYC<1.
//   System requirement: SETTLE_CYC*T_clk >= 3*(T_clk_a+T_clk_b) plus margin. This covers the
//   3-flop chains in both source domains.
// CONFIGURATION
//   CLK_SW_CNT_EN defined:
//     - sw_cnt increments by 1 on each SETTLE->DWELL transition
//     - same-select requests do not increment it
//     - saturates at all-ones
//     - cleared only by rst_n
//   CLK_SW_CNT_EN undefined: no sw_cnt port and no counter logic. All other behaviour is identical.
// STRUCTURE
//   Package clk_sw_pkg:
//     - state typedef: IDLE=2'b00, SETTLE=2'b01, DWELL=2'b10, DONE=2'b11
//     - constants SEL_A=1'b0, SEL_B=1'b1
//   One sub-module, clk_sw_dncnt: loadable down-counter with a zero flag, parameter CW.
//     - a single instance, shared by SETTLE and DWELL
//   The FSM and output registers live in clk_switch_ctrl.
// TESTING (SETTLE_CYC=16, DWELL_CYC=64)
//   1. Reset: rst_n=0 then release; no requests ->
//      clk_sel=0, cur_sel=0, busy=0, done=0, req_ready=1.
//   2. req_sel=1 accepted at edge T ->
//      clk_sel=1 at T+1, cur_sel=1 at T+17, done pulse at T+81, req_ready=1 at T+82.
//   3. With cur_sel=1, send req_sel=1 -> done at T+1, clk_sel unchanged, sw_cnt unchanged.
//   4. Hold req_valid high throughout a switch with req_sel toggling while busy ->
//      only the first request takes effect; the next is accepted at T+82.
//   5. Assert rst_n=0 during DWELL of a 0->1 switch ->
//      outputs go to reset values immediately; the FSM is in IDLE after release.
//   6. With CLK_SW_CNT_EN: 5 real switches plus 3 same-select requests -> sw_cnt=5.
//      With SWCNT_W=2 and 5 switches -> sw_cnt saturates at 3.

Source files
------------

// File: rtl/clk_sw_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_sw_pkg
// Brief   : Shared types and constants for the clock-switch sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package clk_sw_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETTLE = 2'b01,
      DWELL  = 2'b10,
      DONE   = 2'b11
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_switch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : clk_switch_ctrl_if
// Brief   : Request handshake and status bundle of the clock-switch sequencer.
//           sw_cnt is present only when CLK_SW_CNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface clk_switch_ctrl_if #(
   parameter int SWCNT_W = 16
);
   logic req_valid;
   logic req_sel;
   logic req_ready;
   logic clk_sel;
   logic cur_sel;
   logic busy;
   logic done;
`ifdef CLK_SW_CNT_EN
   logic [SWCNT_W-1:0] sw_cnt;

   modport master (output req_valid, req_sel,
                   input  req_ready, clk_sel, cur_sel, busy, done, sw_cnt);
   modport slave  (input  req_valid, req_sel,
                   output req_ready, clk_sel, cur_sel, busy, done, sw_cnt);
`else
   modport master (output req_valid, req_sel,
                   input  req_ready, clk_sel, cur_sel, busy, done);
   modport slave  (input  req_valid, req_sel,
                   output req_ready, clk_sel, cur_sel, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/clk_sw_dncnt.sv
`default_nettype none
// ============================================================================
// Module  : clk_sw_dncnt
// Brief   : Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
module clk_sw_dncnt #(
   parameter int CW = 6
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          i_load,
   input  wire logic [CW-1:0] i_load_val,
   output logic               o_zero
);
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_switch_ctrl
// Brief   : Sequencer for the glitch-free two-source clock switch: drives clk_sel,
//           waits for settle, enforces dwell, pulses done. Optional switch counter
//           enabled by defining CLK_SW_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module clk_switch_ctrl
   import clk_sw_pkg::*;
#(
   parameter int SETTLE_CYC = 16,
   parameter int DWELL_CYC  = 64,
   parameter int SWCNT_W    = 16
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   clk_switch_ctrl_if.slave  bus
);
   localparam int            c_CW        = $clog2(max_int(SETTLE_CYC, DWELL_CYC));
   localparam logic [c_CW-1:0] c_SETTLE_LD = c_CW'(SETTLE_CYC - 1);
   localparam logic [c_CW-1:0] c_DWELL_LD  = c_CW'(DWELL_CYC - 1);

   if (SETTLE_CYC < 4 || DWELL_CYC < 1) begin : g_param_chk
      $error("clk_switch_ctrl: SETTLE_CYC must be >= 4 and DWELL_CYC >= 1");
   end

   state_t            r_state;
   logic              r_clk_sel;
   logic              r_cur_sel;
   logic              r_busy;
   logic              r_done;
   logic              w_accept;
   logic              w_start_sw;
   logic              w_cnt_zero;
   logic              w_load;
   logic [c_CW-1:0]   w_load_val;

   assign w_accept   = bus.req_valid && (r_state == IDLE);
   assign w_start_sw = w_accept && (bus.req_sel != r_cur_sel);

   // One counter serves both timed phases: load settle on accept, dwell on settle expiry
   assign w_load     = w_start_sw || ((r_state == SETTLE) && w_cnt_zero);
   assign w_load_val = (r_state == IDLE) ? c_SETTLE_LD : c_DWELL_LD;

   clk_sw_dncnt #(.CW(c_CW)) u_dncnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_clk_sel <= SEL_A;
         r_cur_sel <= SEL_A;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_busy <= 1'b1;
                  if (w_start_sw) begin
                     r_clk_sel <= bus.req_sel;
                     r_state   <= SETTLE;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            SETTLE: begin
               if (w_cnt_zero) begin
                  r_cur_sel <= r_clk_sel;
                  r_state   <= DWELL;
               end
            end
            DWELL: begin
               if (w_cnt_zero) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.clk_sel   = r_clk_sel;
   assign bus.cur_sel   = r_cur_sel;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

`ifdef CLK_SW_CNT_EN
   logic [SWCNT_W-1:0] r_sw_cnt;

   // Counts only real switches, at the moment the new source is known to be live
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_cnt <= '0;
      end else if ((r_state == SETTLE) && w_cnt_zero && (r_sw_cnt != '1)) begin
         r_sw_cnt <= r_sw_cnt + 1'b1;
      end
   end

   assign bus.sw_cnt = r_sw_cnt;
`endif

endmodule
`default_nettype wire
